// File: rtl/p4_demux_sched.sv
// p4_demux_sched: per-frame route scheduler for the header/payload demux.
// Optional per-port statistics under `P4_DEMUX_SCHED_STATS_EN.
module p4_demux_sched #(
  parameter int M_COUNT = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  localparam int CL = (M_COUNT > 1) ? $clog2(M_COUNT) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_route_valid,
  output logic          s_route_ready,
  input  logic [CL-1:0] s_route_port,
  input  logic          s_route_drop,
  input  logic          hdr_tvalid,
  input  logic          hdr_tready,
  input  logic          hdr_tlast,
  input  logic          pld_tvalid,
  input  logic          pld_tready,
  input  logic          pld_tlast,
  output logic          hdr_enable,
  output logic          pld_enable,
  output logic [CL-1:0] select,
  output logic          drop,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  input  logic          timeout_clr,
  output logic          timeout_err
`ifdef P4_DEMUX_SCHED_STATS_EN
  ,
  output logic [M_COUNT*32-1:0] stat_frames,
  output logic [31:0]           stat_drops
`endif
);

  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic          drop;
    logic [CL-1:0] port;
  } route_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_PLD,
    WAIT_HDR
  } state_t;

  state_t        state_q, state_d;
  route_t        mem [DEPTH];
  route_t        in_r, load_val;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] count;
  logic [TW-1:0] wait_cnt;
  logic          full, empty, push, retire, load;
  logic          hdr_done, pld_done;
  logic          in_wait, next_wait, to_set;

  assign in_r     = {s_route_drop, s_route_port};
  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = s_route_valid && !full;
  assign rd_nxt   = rd_ptr + 1'b1;
  assign hdr_done = hdr_tvalid && hdr_tready && hdr_tlast;
  assign pld_done = pld_tvalid && pld_tready && pld_tlast;

  assign s_route_ready = !full;
  assign fifo_level    = count;
  assign busy          = (state_q != IDLE);
  assign hdr_enable    = (state_q == ACTIVE) || (state_q == WAIT_HDR);
  assign pld_enable    = (state_q == ACTIVE) || (state_q == WAIT_PLD);

  always_comb begin
    retire = 1'b0;
    unique case (1'b1)
      (state_q == ACTIVE):   retire = hdr_done && pld_done;
      (state_q == WAIT_PLD): retire = pld_done;
      (state_q == WAIT_HDR): retire = hdr_done;
      default:               retire = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = mem[rd_ptr];
    unique case (state_q)
      IDLE: begin
        if (!empty || push) begin
          state_d  = ACTIVE;
          load     = 1'b1;
          load_val = empty ? in_r : mem[rd_ptr];
        end
      end
      ACTIVE: begin
        if (hdr_done && !pld_done)
          state_d = WAIT_PLD;
        else if (pld_done && !hdr_done)
          state_d = WAIT_HDR;
      end
      default: ;
    endcase
    // A same-cycle push lets the next pair start without an IDLE bubble.
    if (retire) begin
      if (count > LW'(1)) begin
        state_d  = ACTIVE;
        load     = 1'b1;
        load_val = mem[rd_nxt];
      end else if (push) begin
        state_d  = ACTIVE;
        load     = 1'b1;
        load_val = in_r;
      end else begin
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      select  <= '0;
      drop    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (retire)
        rd_ptr <= rd_nxt;
      if (push && !retire)
        count <= count + 1'b1;
      else if (!push && retire)
        count <= count - 1'b1;
      if (load) begin
        select <= load_val.port;
        drop   <= load_val.drop;
      end
    end
  end

  assign in_wait   = (state_q == WAIT_PLD) || (state_q == WAIT_HDR);
  assign next_wait = (state_d == WAIT_PLD) || (state_d == WAIT_HDR);
  assign to_set    = (TIMEOUT > 0) && in_wait &&
                     (wait_cnt == TW'(TLIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (in_wait && next_wait) begin
        if (wait_cnt != TW'(TIMEOUT))
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (to_set)
        timeout_err <= 1'b1;
      else if (timeout_clr)
        timeout_err <= 1'b0;
    end
  end

`ifdef P4_DEMUX_SCHED_STATS_EN
  logic [31:0] frames_q [M_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M_COUNT; i++)
        frames_q[i] <= '0;
      stat_drops <= '0;
    end else if (retire) begin
      if (drop)
        stat_drops <= stat_drops + 1'b1;
      for (int i = 0; i < M_COUNT; i++)
        if (!drop && select == CL'(i))
          frames_q[i] <= frames_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < M_COUNT; g++) begin : g_stat
    assign stat_frames[g*32 +: 32] = frames_q[g];
  end
`endif

endmodule

// File: tb/tb_p4_demux_sched.sv
// tb_p4_demux_sched: directed scoreboard bench for p4_demux_sched.
// Build with +define+P4_DEMUX_SCHED_STATS_EN to also cover the counters.
module tb_p4_demux_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_route_valid = 0, s_route_ready;
  logic [1:0] s_route_port = 0;
  logic       s_route_drop = 0;
  logic       hdr_tvalid = 0, hdr_tready = 0, hdr_tlast = 0;
  logic       pld_tvalid = 0, pld_tready = 0, pld_tlast = 0;
  logic       hdr_enable, pld_enable, drop, busy;
  logic [1:0] select;
  logic [2:0] fifo_level;
  logic       timeout_clr = 0, timeout_err;
`ifdef P4_DEMUX_SCHED_STATS_EN
  logic [127:0] stat_frames;
  logic [31:0]  stat_drops;
`endif

  always #5 clk = ~clk;

  p4_demux_sched #(
    .M_COUNT(4),
    .DEPTH(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_route_valid(s_route_valid),
    .s_route_ready(s_route_ready),
    .s_route_port(s_route_port),
    .s_route_drop(s_route_drop),
    .hdr_tvalid(hdr_tvalid),
    .hdr_tready(hdr_tready),
    .hdr_tlast(hdr_tlast),
    .pld_tvalid(pld_tvalid),
    .pld_tready(pld_tready),
    .pld_tlast(pld_tlast),
    .hdr_enable(hdr_enable),
    .pld_enable(pld_enable),
    .select(select),
    .drop(drop),
    .busy(busy),
    .fifo_level(fifo_level),
    .timeout_clr(timeout_clr),
    .timeout_err(timeout_err)
`ifdef P4_DEMUX_SCHED_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_drops(stat_drops)
`endif
  );

  typedef struct packed {
    logic [1:0] port;
    logic       drop;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t hq[$];
  exp_t pq[$];
  exp_t hc, pc;
  bit   h_in, p_in;
  int   exp_frames[4] = '{0, 0, 0, 0};
  int   exp_drops = 0;
  bit   wait_seen;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic queue_exp(int port, bit drp);
    exp_t e;
    e.port = 2'(port);
    e.drop = drp;
    hq.push_back(e);
    pq.push_back(e);
    if (drp) exp_drops++;
    else exp_frames[port]++;
  endtask

  task automatic push(int port, bit drp);
    check("push_ready", s_route_ready, 1);
    s_route_valid = 1;
    s_route_port  = 2'(port);
    s_route_drop  = drp;
    queue_exp(port, drp);
    cyc();
    s_route_valid = 0;
  endtask

  task automatic frames(int hl, int pl);
    int h, p, n;
    h = 0;
    p = 0;
    n = 0;
    wait_seen = 0;
    while ((h < hl || p < pl) && n < 64) begin
      hdr_tvalid = (h < hl) && hdr_enable;
      hdr_tready = hdr_tvalid;
      hdr_tlast  = hdr_tvalid && (h == hl - 1);
      pld_tvalid = (p < pl) && pld_enable;
      pld_tready = pld_tvalid;
      pld_tlast  = pld_tvalid && (p == pl - 1);
      cyc();
      n++;
      if (hdr_tvalid) h++;
      if (pld_tvalid) p++;
      if (h < hl || p < pl) begin
        if (hdr_enable != pld_enable) wait_seen = 1;
        if (h >= hl) begin
          check("wait_pld_hen", hdr_enable, 0);
          check("wait_pld_pen", pld_enable, 1);
        end
        if (p >= pl) begin
          check("wait_hdr_hen", hdr_enable, 1);
          check("wait_hdr_pen", pld_enable, 0);
        end
      end
    end
    hdr_tvalid = 0; hdr_tready = 0; hdr_tlast = 0;
    pld_tvalid = 0; pld_tready = 0; pld_tlast = 0;
    if (h < hl || p < pl) begin
      n_chk++;
      n_fail++;
      $display("FAIL frames_bound: got h=%0d p=%0d want %0d/%0d",
               h, p, hl, pl);
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_hen"}, hdr_enable, 0);
    check({tag, "_pen"}, pld_enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sel"}, select, 0);
    check({tag, "_drop"}, drop, 0);
    check({tag, "_lvl"}, fifo_level, 0);
    check({tag, "_rdy"}, s_route_ready, 1);
    check({tag, "_terr"}, timeout_err, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      h_in = 0;
      p_in = 0;
    end else begin
      if (hdr_tvalid && hdr_tready && hdr_enable) begin
        if (!h_in) begin
          if (hq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL hdr_unexpected: got frame want none");
          end else begin
            hc = hq.pop_front();
          end
        end
        check("hdr_select", select, hc.port);
        check("hdr_drop", drop, hc.drop);
        h_in = !hdr_tlast;
      end
      if (pld_tvalid && pld_tready && pld_enable) begin
        if (!p_in) begin
          if (pq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pld_unexpected: got frame want none");
          end else begin
            pc = pq.pop_front();
          end
        end
        check("pld_select", select, pc.port);
        check("pld_drop", drop, pc.drop);
        p_in = !pld_tlast;
      end
    end
  end

  initial begin
    #1 rst_n = 0;
    #1 check_reset("rst");
    #20;
    @(negedge clk) rst_n = 1;
    cyc();

    // single pair, header finishes first
    check("t1_idle_hen", hdr_enable, 0);
    push(2, 0);
    check("t1_hen", hdr_enable, 1);
    check("t1_pen", pld_enable, 1);
    check("t1_sel", select, 2);
    check("t1_busy", busy, 1);
    check("t1_lvl", fifo_level, 1);
    frames(3, 5);
    check("t1_wait", wait_seen, 1);
    check("t1_busy_end", busy, 0);
    check("t1_lvl_end", fifo_level, 0);
    check("t1_hen_end", hdr_enable, 0);

    // simultaneous tlast goes straight to the next decision
    push(3, 0);
    push(1, 0);
    check("t2_lvl", fifo_level, 2);
    frames(2, 2);
    check("t2_nowait", wait_seen, 0);
    check("t2_sel", select, 1);
    check("t2_busy", busy, 1);
    check("t2_hen", hdr_enable, 1);
    check("t2_lvl1", fifo_level, 1);
    frames(1, 1);
    check("t2_busy_end", busy, 0);

    // fill, back-to-back retires, push during pop
    push(0, 0);
    push(1, 0);
    push(2, 0);
    push(3, 0);
    check("t3_full_rdy", s_route_ready, 0);
    check("t3_lvl4", fifo_level, 4);
    check("t3_sel0", select, 0);
    frames(1, 1);
    check("t3_sel1", select, 1);
    check("t3_lvl3", fifo_level, 3);
    check("t3_busy1", busy, 1);
    s_route_valid = 1;
    s_route_port  = 2'd0;
    s_route_drop  = 0;
    queue_exp(0, 0);
    frames(1, 1);
    s_route_valid = 0;
    check("t3_lvl_same", fifo_level, 3);
    check("t3_sel2", select, 2);
    check("t3_busy2", busy, 1);
    frames(1, 1);
    check("t3_sel3", select, 3);
    check("t3_lvl2", fifo_level, 2);
    frames(1, 1);
    check("t3_sel0b", select, 0);
    check("t3_lvl1", fifo_level, 1);
    frames(1, 1);
    check("t3_busy_end", busy, 0);
    check("t3_lvl0", fifo_level, 0);

    // drop decision
    push(1, 1);
    check("t4_drop", drop, 1);
    check("t4_sel", select, 1);
    frames(2, 3);
    check("t4_busy_end", busy, 0);
`ifdef P4_DEMUX_SCHED_STATS_EN
    check("t4_stat_drops", stat_drops, 32'(exp_drops));
    check("t4_stat_p1", stat_frames[32 +: 32], 32'(exp_frames[1]));
    check("t4_stat_p2", stat_frames[64 +: 32], 32'(exp_frames[2]));
`endif

    // payload stall past the timeout
    push(0, 0);
    hdr_tvalid = 1; hdr_tready = 1; hdr_tlast = 1;
    cyc();
    hdr_tvalid = 0; hdr_tready = 0; hdr_tlast = 0;
    check("t5_hen", hdr_enable, 0);
    check("t5_pen", pld_enable, 1);
    repeat (15) cyc();
    check("t5_err_15", timeout_err, 0);
    cyc();
    check("t5_err_16", timeout_err, 1);
    repeat (4) cyc();
    check("t5_err_20", timeout_err, 1);
    check("t5_busy", busy, 1);
    frames(0, 1);
    check("t5_err_hold", timeout_err, 1);
    check("t5_busy_end", busy, 0);
    timeout_clr = 1;
    cyc();
    timeout_clr = 0;
    check("t5_err_clr", timeout_err, 0);

    // reset while waiting on payload
    push(2, 0);
    push(3, 0);
    hdr_tvalid = 1; hdr_tready = 1; hdr_tlast = 1;
    cyc();
    hdr_tvalid = 0; hdr_tready = 0; hdr_tlast = 0;
    check("t6_wait_hen", hdr_enable, 0);
    check("t6_lvl", fifo_level, 2);
    #1 rst_n = 0;
    #1 check_reset("t6");
    hq.delete();
    pq.delete();
    @(negedge clk) rst_n = 1;
    cyc();
    check("t6_busy_after", busy, 0);
    check("t6_lvl_after", fifo_level, 0);

    check("hq_empty", hq.size(), 0);
    check("pq_empty", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
